// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared state encoding, forward-select codes and widths for
//               the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDSTALL  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Combinational ALU operand source select; MEM beats WB, $0 is
//               never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel #(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] rw_mem,
    input  logic              wr_mem,
    input  logic [REG_AW-1:0] rw_wb,
    input  logic              wr_wb,
    output logic [1:0]        sel
);
    import hazard_ctrl_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (wr_mem && (rw_mem != '0) && (rw_mem == src)) begin
            sel = FWD_MEM;
        end else if (wr_wb && (rw_wb != '0) && (rw_wb == src)) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, redirect flush and EX operand forwarding
//               control for the five-stage pipeline. Optional statistics
//               counters are built when HAZARD_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rw_ex,
    input  logic              Regwrite_ex,
    input  logic              MemToReg_ex,
    input  logic              taken_ex,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import hazard_ctrl_pkg::*;

    state_t            r_state;
    logic [REG_AW-1:0] r_rw_mem;
    logic [REG_AW-1:0] r_rw_wb;
    logic              r_wr_mem;
    logic              r_wr_wb;

    logic w_lu;
    logic w_taken;
    logic w_stall;

    assign w_lu = Regwrite_ex && MemToReg_ex && (rw_ex != '0) &&
                  ((use_rs_id && (rs_id == rw_ex)) ||
                   (use_rt_id && (rt_id == rw_ex)));

    // Reset masks the control outputs so rst with taken_ex is reset only.
    assign w_taken = taken_ex && !rst;
    assign w_stall = !rst && w_lu && !taken_ex && (r_state == RUN);

    assign stall_pc    = w_stall;
    assign stall_if_id = w_stall;
    assign flush_if_id = w_taken;
    assign flush_id_ex = w_taken || w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_rw_mem <= '0;
            r_wr_mem <= 1'b0;
            r_rw_wb  <= '0;
            r_wr_wb  <= 1'b0;
        end else begin
            if (w_taken) begin
                r_state <= REDIRECT;
            end else if (w_stall) begin
                r_state <= LDSTALL;
            end else begin
                r_state <= RUN;
            end
            // A redirect flush also drops the EX write from the MEM shadow.
            r_rw_mem <= rw_ex;
            r_wr_mem <= Regwrite_ex && !(flush_id_ex && taken_ex);
            r_rw_wb  <= r_rw_mem;
            r_wr_wb  <= r_wr_mem;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src    (rs_ex),
        .rw_mem (r_rw_mem),
        .wr_mem (r_wr_mem),
        .rw_wb  (r_rw_wb),
        .wr_wb  (r_wr_wb),
        .sel    (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src    (rt_ex),
        .rw_mem (r_rw_mem),
        .wr_mem (r_wr_mem),
        .rw_wb  (r_rw_wb),
        .wr_wb  (r_wr_wb),
        .sel    (fwd_b)
    );

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_pc) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush_if_id) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire
